alu_op_sequencer: RTL and testbench

- Multi-cycle controller that drives the 16-bit combinational ALU and builds composite operations from its four primitives: FUN 00 ADD, 01 AND, 10 NOT(A), 11 SHR1(A).
- Sits between the CPU control unit, which issues commands, and the ALU.
- Accepts one command over a valid/ready handshake and runs the primitive steps needed.
- Returns a registered result with flags over a second valid/ready handshake.

---
 rtl/alu_op_sequencer_pkg.sv | 28 ++
 rtl/alu_step_decode.sv | 104 ++++++++++
 rtl/alu_op_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU op sequencer.
// Opcodes, ALU FUN selects, FSM states and defaults.
package alu_op_sequencer_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_AND = 2'b01;
  localparam logic [1:0] FUN_NOT = 2'b10;
  localparam logic [1:0] FUN_SHR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_step_decode.sv
// Maps (op, step, operands, temps) to the ALU inputs
// for one EXEC cycle, plus capture target and last-step.
module alu_step_decode
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] step,
  input  logic [CNT_W-1:0] cnt,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] u,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_fun,
  output logic             last_step,
  output logic             dst_u
);

  logic s0, s1, s2, s_last;

  assign s0     = (step == CNT_W'(0));
  assign s1     = (step == CNT_W'(1));
  assign s2     = (step == CNT_W'(2));
  assign s_last = (step == cnt - CNT_W'(1));

  // Step table; ALU inputs are idle-zero outside EXEC
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_fun   = FUN_ADD;
    last_step = 1'b0;
    dst_u     = 1'b0;
    if (en) begin
      unique case (1'b1)
        op == OP_ADD: begin
          alu_a     = opa;
          alu_b     = opb;
          last_step = 1'b1;
        end
        op == OP_AND: begin
          alu_a     = opa;
          alu_b     = opb;
          alu_fun   = FUN_AND;
          last_step = 1'b1;
        end
        op == OP_NOT: begin
          alu_a     = opa;
          alu_fun   = FUN_NOT;
          last_step = 1'b1;
        end
        op == OP_SUB: begin
          if (s0) begin
            alu_a   = opb;
            alu_fun = FUN_NOT;
          end else if (s1) begin
            alu_a = opa;
            alu_b = t;
          end else begin
            alu_a     = t;
            alu_b     = WIDTH'(1);
            last_step = 1'b1;
          end
        end
        op == OP_OR: begin
          if (s0) begin
            alu_a   = opa;
            alu_fun = FUN_NOT;
          end else if (s1) begin
            alu_a   = opb;
            alu_fun = FUN_NOT;
            dst_u   = 1'b1;
          end else if (s2) begin
            alu_a   = t;
            alu_b   = u;
            alu_fun = FUN_AND;
          end else begin
            alu_a     = t;
            alu_fun   = FUN_NOT;
            last_step = 1'b1;
          end
        end
        op == OP_SHR: begin
          alu_a     = t;
          alu_fun   = FUN_SHR;
          last_step = s_last;
        end
        op == OP_SHL: begin
          alu_a     = t;
          alu_b     = t;
          last_step = s_last;
        end
        default: begin
          last_step = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer building composite ops on a 4-function ALU.
// Optional EXEC-cycle counter perf_busy under ALU_SEQ_PERF_EN.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_z
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_busy
`endif
);

  state_e           state;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa, opb, t, u;
  logic [CNT_W-1:0] step, cnt;
  logic             last_step, dst_u;
  logic             is_shift;

  assign is_shift = (cmd_op == OP_SHR) || (cmd_op == OP_SHL);

  alu_step_decode #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dec (
    .en        (state == S_EXEC),
    .op        (op),
    .step      (step),
    .cnt       (cnt),
    .opa       (opa),
    .opb       (opb),
    .t         (t),
    .u         (u),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_fun   (alu_fun),
    .last_step (last_step),
    .dst_u     (dst_u)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_err   <= 1'b0;
      op        <= OP_ADD;
      opa       <= '0;
      opb       <= '0;
      t         <= '0;
      u         <= '0;
      step      <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op        <= cmd_op;
            opa       <= cmd_a;
            opb       <= cmd_b;
            cnt       <= cmd_cnt;
            t         <= cmd_a;
            u         <= '0;
            step      <= '0;
            cmd_ready <= 1'b0;
            if (cmd_op == OP_ILL) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_data  <= '0;
              res_zero  <= 1'b1;
              res_err   <= 1'b1;
            end else if (is_shift && cmd_cnt == '0) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_data  <= cmd_a;
              res_zero  <= (cmd_a == '0);
              res_err   <= 1'b0;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (dst_u) u <= alu_z;
          else       t <= alu_z;
          step <= step + CNT_W'(1);
          if (last_step) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
            res_data  <= alu_z;
            res_zero  <= (alu_z == '0);
            res_err   <= 1'b0;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Saturating count of cycles spent in EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_busy <= '0;
    else if (state == S_EXEC && perf_busy != '1)
      perf_busy <= perf_busy + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer.
// Bench supplies the combinational ALU; checks via immediate asserts.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  typedef struct {
    logic [15:0] d;
    logic        z;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [3:0]  cmd_cnt = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_zero;
  logic        res_err;
  logic [15:0] alu_a, alu_b, alu_z;
  logic [1:0]  alu_fun;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_busy;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic [1:0] fseq[$];
  int   lat_seen;

  always #5 clk = ~clk;

  // Reference ALU, combinational
  always_comb begin
    case (alu_fun)
      2'b00:   alu_z = alu_a + alu_b;
      2'b01:   alu_z = alu_a & alu_b;
      2'b10:   alu_z = ~alu_a;
      default: alu_z = alu_a >> 1;
    endcase
  end

  alu_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_cnt   (cmd_cnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_err   (res_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_fun   (alu_fun),
    .alu_z     (alu_z)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_busy (perf_busy)
`endif
  );

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic [3:0] c);
    exp_t r;
    r.e = 1'b0;
    case (op)
      3'b000:  r.d = a + b;
      3'b001:  r.d = a & b;
      3'b010:  r.d = ~a;
      3'b011:  r.d = a >> c;
      3'b100:  r.d = a - b;
      3'b101:  r.d = a | b;
      3'b110:  r.d = a << c;
      default: begin r.d = '0; r.e = 1'b1; end
    endcase
    r.z = (r.d == 16'h0);
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_data"}, 32'(res_data), 32'(e.d));
      check({tag, "_zero"}, 32'(res_zero), 32'(e.z));
      check({tag, "_err"}, 32'(res_err), 32'(e.e));
    end
  endtask

  // One full command: send, wait result, compare, retire
  task automatic run(input string tag, input logic [2:0] op,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] c, input int lat);
    sb.push_back(model(op, a, b, c));
    fseq.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cnt   = c;
    check({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat_seen  = 0;
    while (!res_valid && lat_seen < 200) begin
      fseq.push_back(alu_fun);
      @(posedge clk);
      #1;
      lat_seen++;
    end
    if (lat >= 0) check({tag, "_lat"}, 32'(lat_seen), 32'(lat));
    pop_check(tag);
    check({tag, "_busy"}, 32'(cmd_ready), 32'd0);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_clr"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_rdy", 32'(cmd_ready), 32'd1);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_fun", 32'(alu_fun), 32'd0);
    check("rst_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("add", OP_ADD, 16'h1234, 16'h1111, 4'd0, 1);
    check("add_fun", 32'(fseq[0]), 32'(FUN_ADD));
    run("and", OP_AND, 16'hF0CC, 16'h3CAA, 4'd0, 1);
    run("not", OP_NOT, 16'h00FF, 16'h0000, 4'd0, 1);
    run("sub", OP_SUB, 16'h0005, 16'h0007, 4'd0, 3);
    run("subz", OP_SUB, 16'h00AA, 16'h00AA, 4'd0, 3);
    run("or", OP_OR, 16'hF0F0, 16'h0F0F, 4'd0, 4);
    check("or_f0", 32'(fseq[0]), 32'(FUN_NOT));
    check("or_f1", 32'(fseq[1]), 32'(FUN_NOT));
    check("or_f2", 32'(fseq[2]), 32'(FUN_AND));
    check("or_f3", 32'(fseq[3]), 32'(FUN_NOT));
    run("or2", OP_OR, 16'h1200, 16'h0034, 4'd0, 4);
    run("shr15", OP_SHR, 16'h8000, 16'h0000, 4'd15, 15);
    run("shl1", OP_SHL, 16'h8001, 16'h0000, 4'd1, 1);
    run("shl3", OP_SHL, 16'h1235, 16'h0000, 4'd3, 3);
    run("shr0", OP_SHR, 16'hBEEF, 16'h0000, 4'd0, -1);
    run("shl0", OP_SHL, 16'h0000, 16'h0000, 4'd0, -1);

    // Illegal op, then hold the result while a new command knocks
    sb.push_back(model(OP_ILL, 16'h5555, 16'h0000, 4'd0));
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_ILL;
    cmd_a     = 16'h5555;
    @(posedge clk);
    #1;
    cmd_op = OP_ADD;
    cmd_a  = 16'h0001;
    cmd_b  = 16'h0001;
    pop_check("ill");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_err", 32'(res_err), 32'd1);
      check("hold_data", 32'(res_data), 32'd0);
      check("hold_rdy", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ign_valid", 32'(res_valid), 32'd0);
    check("ign_rdy", 32'(cmd_ready), 32'd1);

    // Asynchronous reset in the middle of an OR
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_OR;
    cmd_a     = 16'hF0F0;
    cmd_b     = 16'h0F0F;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_fun", 32'(alu_fun), 32'(FUN_AND));
    check("mid_zero", 32'(res_zero), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rdy", 32'(cmd_ready), 32'd1);
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_fun", 32'(alu_fun), 32'd0);
    check("arst_a", 32'(alu_a), 32'd0);
    check("arst_b", 32'(alu_b), 32'd0);
    check("arst_zero", 32'(res_zero), 32'd0);
    check("arst_err", 32'(res_err), 32'd0);
    check("arst_data", 32'(res_data), 32'd0);
`ifdef ALU_SEQ_PERF_EN
    check("perf_rst", perf_busy, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run("post", OP_ADD, 16'h0001, 16'h0001, 4'd0, 1);
`ifdef ALU_SEQ_PERF_EN
    check("perf_post", perf_busy, 32'd1);
`endif
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
